mult_div_ctrl: RTL
==================

# mult_div_ctrl

Sequential signed multiply/divide engine and its controller, feeding the HI and LO registers of the multicycle MIPS datapath. The main control FSM starts an operation with a one-cycle `mult_start` or `div_start` pulse, using operands from the A and B registers. It holds in a wait state while `busy` is high and resumes on the `done` pulse. HI/LO are held inside this block and drive the HI/LO inputs of the register-write data mux.

## Interface
- No parameters; operand width fixed at 32.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `mult_start` in 1: single-cycle request, signed multiply a*b.
- `div_start` in 1: single-cycle request, signed divide a/b.
- `a` in 32: multiplicand / dividend, sampled at start.
- `b` in 32: multiplier / divisor, sampled at start.
- `hi` out 32: HI register (product high word / remainder).
- `lo` out 32: LO register (product low word / quotient).
- `busy` out 1: operation in progress (RUN or FIN).
- `done` out 1: one-cycle completion pulse; hi/lo already valid while high.
- `div_zero` out 1: one-cycle pulse, concurrent with `done`, on divide by zero.

## Operation
- States: IDLE, RUN, FIN.
- IDLE:
  - `mult_start`=1: latch a, b and op=MULT; clear the 5-bit iteration counter; go to RUN.
  - `div_start`=1: same, with op=DIV.
  - Both high in the same cycle: mult wins and the div request is dropped.
- Start pulses in RUN or FIN are ignored, with no queuing.
- Multiply: radix-2 Booth over 32 iterations, one per cycle, producing a 64-bit signed product.
  - Accumulator 33 bits with arithmetic right shift.
  - In FIN, hi={product[63:32]} and lo={product[31:0]}.
- Divide: unsigned restoring division on operand magnitudes, one quotient bit per cycle for 32 cycles, then sign fix-up.
  - Quotient negated iff sign(a) xor sign(b).
  - Remainder takes the sign of a; quotient truncates toward zero (MIPS semantics).
  - |0x80000000| is handled as unsigned 0x80000000.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- RUN → FIN when the counter reaches 31 (after the 32nd iteration).
- FIN: hi/lo are written on entry; `done`=1 for the FIN cycle; FIN → IDLE unconditionally.
- hi/lo change only on entry to FIN and hold all other times, including across subsequent idle cycles.
- Reset (async, any state): state=IDLE, counter=0, hi=lo=0, busy=done=div_zero=0. The operation in flight is abandoned.

## Timing
- Let E0 be the rising edge that samples a start in IDLE.
- `busy`=1 from E0 through E33; it falls at E33.
- Iterations occur at E1..E32. FIN is entered at E32, where hi/lo are written and `done` rises.
- `done` falls at E33, giving a mult/div latency of 32 cycles from start edge to `done`.
- A new start is accepted no earlier than E33, i.e. the cycle after `done`.
- All outputs are registered, with no combinational path from inputs to outputs.
- Divide by zero, with the feature enabled: IDLE → FIN directly at E0. `done` and `div_zero` are high for the cycle E0–E1, and hi/lo are unchanged.

## Configuration
- Macro: `MULT_DIV_CTRL_DIV_ZERO_EN`.
- Defined:
  - A divide with b==0 is detected at start and short-circuits to FIN as described in Timing.
  - `div_zero` pulses and hi/lo are preserved, so the control FSM can raise its exception.
- Undefined:
  - No detection; the divide runs the full 32 iterations and `div_zero` is tied to 0.
  - Result: hi=a. lo=0xFFFFFFFF if a≥0, else 0x00000001.

## Test plan
- Multiply:
  - a=7, b=0xFFFFFFFD, pulse `mult_start` → `done` 32 cycles later with hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - a=b=0x80000000 → hi=0x40000000, lo=0x00000000.
- Divide:
  - a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF, after 32 cycles.
  - a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0x00000000.
- Divide by zero, starting from hi=0x11, lo=0x22, with a=5, b=0:
  - Macro defined → `done`=`div_zero`=1 on the cycle after the start edge; hi=0x11, lo=0x22; `busy` low 2 edges after start.
  - Macro undefined → after 32 cycles hi=5, lo=0xFFFFFFFF, `div_zero`=0.
- Arbitration and busy:
  - `mult_start` and `div_start` in the same cycle with a=6, b=3 → multiply result hi=0, lo=18.
  - A second `mult_start` at cycle 10 of RUN → ignored; exactly one `done` pulse.
- Reset mid-operation: assert `reset` low for 1 cycle at iteration 15 of a divide → all outputs are 0 immediately, with no `done`. A following multiply 3*4 → lo=12 after 32 cycles.

Source files
------------

// File: rtl/mult_div_ctrl.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring) engine owning HI/LO.
// Optional MULT_DIV_CTRL_DIV_ZERO_EN: short-circuit divide-by-zero to FIN with a div_zero pulse.
module mult_div_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        mult_start,
  input  logic        div_start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t              state_q;
  logic [4:0]          cnt_q;
  logic                op_div_q;
  logic                neg_quo_q, neg_rem_q;
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic                busy_q, done_q;
  logic signed [DATA_W:0] acc_q, acc_d;
  logic [DATA_W-1:0]   q_q, q_d;
  logic                q_m1_q, q_m1_d;
  logic [DATA_W:0]     m_q;
  logic signed [DATA_W:0] booth_sum;
  logic [DATA_W:0]     shifted, diff;
  logic                ge;
  logic [DATA_W-1:0]   hi_d, lo_d;
  logic                accept_mult, accept_div, div_by_zero;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] x, input logic n);
    return n ? (~x + 1'b1) : x;
  endfunction

  assign accept_mult = (state_q == S_IDLE) && mult_start;
  assign accept_div  = (state_q == S_IDLE) && !mult_start && div_start;
`ifdef MULT_DIV_CTRL_DIV_ZERO_EN
  assign div_by_zero = accept_div && (b == '0);
`else
  assign div_by_zero = 1'b0;
`endif

  // One iteration: Booth add/sub + arithmetic shift, or one restoring-division quotient bit
  always_comb begin
    booth_sum = acc_q;
    shifted   = {acc_q[DATA_W-1:0], q_q[DATA_W-1]};
    diff      = shifted - m_q;
    ge        = (shifted >= m_q);
    acc_d     = acc_q;
    q_d       = q_q;
    q_m1_d    = q_m1_q;
    if (!op_div_q) begin
      case ({q_q[0], q_m1_q})
        2'b01:   booth_sum = acc_q + $signed(m_q);
        2'b10:   booth_sum = acc_q - $signed(m_q);
        default: booth_sum = acc_q;
      endcase
      acc_d  = booth_sum >>> 1;
      q_d    = {booth_sum[0], q_q[DATA_W-1:1]};
      q_m1_d = q_q[0];
    end else begin
      acc_d = ge ? {1'b0, diff[DATA_W-1:0]} : {1'b0, shifted[DATA_W-1:0]};
      q_d   = {q_q[DATA_W-2:0], ge};
    end
    if (op_div_q) begin
      hi_d = neg_if(acc_d[DATA_W-1:0], neg_rem_q);
      lo_d = neg_if(q_d, neg_quo_q);
    end else begin
      hi_d = acc_d[DATA_W-1:0];
      lo_d = q_d;
    end
  end

  // Datapath operands and partial results carry no reset; control qualifies their use
  always_ff @(posedge clk) begin
    if (accept_mult) begin
      acc_q    <= '0;
      q_q      <= b;
      q_m1_q   <= 1'b0;
      m_q      <= {a[DATA_W-1], a};
    end else if (accept_div) begin
      acc_q    <= '0;
      q_q      <= mag(a);
      q_m1_q   <= 1'b0;
      m_q      <= {1'b0, mag(b)};
    end else if (state_q == S_RUN) begin
      acc_q    <= acc_d;
      q_q      <= q_d;
      q_m1_q   <= q_m1_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (accept_mult || accept_div) begin
            op_div_q  <= accept_div;
            neg_quo_q <= a[DATA_W-1] ^ b[DATA_W-1];
            neg_rem_q <= a[DATA_W-1];
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            if (div_by_zero) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= S_FIN;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MULT_DIV_CTRL_DIV_ZERO_EN
  logic div_zero_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div_zero_q <= 1'b0;
    else        div_zero_q <= div_by_zero;
  end
  assign div_zero = div_zero_q;
`else
  assign div_zero = 1'b0;
`endif

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule
